// File: rtl/mod_mul_barrett_arbiter.sv
// ---------------------------------------------------------------------------
// mod_mul_barrett_arbiter
//
// Purpose:
//   Shares one pipelined Barrett modular multiplier between NREQ requesters.
//   - Holds the modulus configuration (K, U, Mod) and drives it steadily to
//     the multiplier. It is only rewritten when the pipe is empty.
//   - Grants one requester per cycle in round-robin order and muxes that
//     requester's operands onto the multiplier inputs.
//   - Tracks which requester owns each pipe slot, using a valid/id shift
//     register of depth LAT that advances in lockstep with the multiplier.
//   - Freezes the multiplier (oMulEn=0) and the tracking together while a
//     finished result is waiting on a consumer that is not ready.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising edge of iClk where valid and ready are
//   both 1. Ready may depend combinationally on valid. A producer keeps valid
//   and data stable until the transfer happens.
//
// Ports:
//   iClk, iRstN             clock, asynchronous active-low reset
//   iClr                    sync flush of pipe tracking and RR pointer
//                           (the configuration is kept)
//   iCfgValid/oCfgReady     configuration write channel
//   iCfgK/iCfgU/iCfgMod     bit count, Barrett constant, modulus
//   iReqValid/oReqReady     per-requester request; ready is a one-hot grant
//   iReqData0/iReqData1     operands A/B, requester i at [32i+:32]
//   oRspValid/iRspReady     result channel
//   oRspId/oRspData         owning requester id and (A*B) mod Mod
//   oMulEn/oMulClr          multiplier enable and clear
//   oMulK/oMulU/oMulMod     registered configuration to the multiplier
//   oMulData0/oMulData1     muxed operands to the multiplier
//   iMulData                multiplier result
// ---------------------------------------------------------------------------
module mod_mul_barrett_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 6
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iClr,
  input  logic                 iCfgValid,
  output logic                 oCfgReady,
  input  logic [5:0]           iCfgK,
  input  logic [63:0]          iCfgU,
  input  logic [31:0]          iCfgMod,
  input  logic [NREQ-1:0]      iReqValid,
  output logic [NREQ-1:0]      oReqReady,
  input  logic [NREQ*32-1:0]   iReqData0,
  input  logic [NREQ*32-1:0]   iReqData1,
  output logic                 oRspValid,
  input  logic                 iRspReady,
  output logic [IDW-1:0]       oRspId,
  output logic [31:0]          oRspData,
  output logic                 oMulEn,
  output logic                 oMulClr,
  output logic [5:0]           oMulK,
  output logic [63:0]          oMulU,
  output logic [31:0]          oMulMod,
  output logic [31:0]          oMulData0,
  output logic [31:0]          oMulData1,
  input  logic [31:0]          iMulData
);

  // Registered state.
  logic [5:0]                cfg_k_q,      cfg_k_d;
  logic [63:0]               cfg_u_q,      cfg_u_d;
  logic [31:0]               cfg_mod_q,    cfg_mod_d;
  logic                      cfg_loaded_q, cfg_loaded_d;
  logic [LAT-1:0]            vld_q,        vld_d;
  logic [LAT-1:0][IDW-1:0]   id_q,         id_d;
  logic [IDW-1:0]            ptr_q,        ptr_d;

  // Combinational helpers.
  logic                      mul_en;
  logic                      grant_ok;
  logic                      grant_any;
  logic [IDW-1:0]            grant_id;
  logic [IDW-1:0]            cand;
  logic                      cfg_ready;
  logic [NREQ-1:0]           req_ready;
  logic [31:0]               mul_d0;
  logic [31:0]               mul_d1;

  // Pipe stalls only when the oldest slot holds a result nobody takes.
  assign mul_en = ~(vld_q[LAT-1] & ~iRspReady);

  // Config waits for an empty pipe, so every op in flight sees the same
  // modulus from entry to exit.
  assign cfg_ready = iCfgValid & (vld_q == '0) & ~iClr;

  // A pending config write blocks new grants so the pipe can drain.
  assign grant_ok = cfg_loaded_q & mul_en & ~iCfgValid & ~iClr;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr_q) + off) % NREQ);
      if (!grant_any && iReqValid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    grant_any = grant_any & grant_ok;
  end

  // One-hot grant and operand mux; operands are zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    mul_d0    = '0;
    mul_d1    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_d0       = iReqData0[32*i +: 32];
        mul_d1       = iReqData1[32*i +: 32];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    cfg_k_d      = cfg_k_q;
    cfg_u_d      = cfg_u_q;
    cfg_mod_d    = cfg_mod_q;
    cfg_loaded_d = cfg_loaded_q;
    vld_d        = vld_q;
    id_d         = id_q;
    ptr_d        = ptr_q;

    if (iClr) begin
      vld_d = '0;
      id_d  = '0;
      ptr_d = '0;
    end else begin
      // Tracking moves exactly when the multiplier does.
      if (mul_en) begin
        vld_d = {vld_q[LAT-2:0], grant_any};
        id_d  = {id_q[LAT-2:0], (grant_any ? grant_id : IDW'(0))};
      end
      if (grant_any) begin
        if (int'(grant_id) == NREQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_id + IDW'(1);
        end
      end
      if (cfg_ready) begin
        cfg_k_d      = iCfgK;
        cfg_u_d      = iCfgU;
        cfg_mod_d    = iCfgMod;
        cfg_loaded_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cfg_k_q      <= '0;
      cfg_u_q      <= '0;
      cfg_mod_q    <= '0;
      cfg_loaded_q <= 1'b0;
      vld_q        <= '0;
      id_q         <= '0;
      ptr_q        <= '0;
    end else begin
      cfg_k_q      <= cfg_k_d;
      cfg_u_q      <= cfg_u_d;
      cfg_mod_q    <= cfg_mod_d;
      cfg_loaded_q <= cfg_loaded_d;
      vld_q        <= vld_d;
      id_q         <= id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign oCfgReady = cfg_ready;
  assign oReqReady = req_ready;
  assign oRspValid = vld_q[LAT-1];
  assign oRspId    = id_q[LAT-1];
  assign oRspData  = iMulData;
  assign oMulEn    = mul_en;
  assign oMulClr   = iClr;
  assign oMulK     = cfg_k_q;
  assign oMulU     = cfg_u_q;
  assign oMulMod   = cfg_mod_q;
  assign oMulData0 = mul_d0;
  assign oMulData1 = mul_d1;

endmodule

// File: tb/tb_mod_mul_barrett_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_barrett_arbiter
//
// Bench for the shared Barrett multiplier arbiter. A behavioural multiplier
// with LAT enabled register stages stands in for the real one. Requests come
// from a per-requester op list holding hand-computed results; each grant
// pushes the expected {id, result} into exp_q, and a monitor pops and
// compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_mod_mul_barrett_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 6;
  localparam int W    = IDW + 32;

  // ---------------- clock / reset ----------------
  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------- DUT signals ----------------
  logic               iClr = 1'b0;
  logic               iCfgValid = 1'b0;
  logic               oCfgReady;
  logic [5:0]         iCfgK = '0;
  logic [63:0]        iCfgU = '0;
  logic [31:0]        iCfgMod = '0;
  logic [NREQ-1:0]    iReqValid = '0;
  logic [NREQ-1:0]    oReqReady;
  logic [NREQ*32-1:0] iReqData0 = '0;
  logic [NREQ*32-1:0] iReqData1 = '0;
  logic               oRspValid;
  logic               iRspReady = 1'b1;
  logic [IDW-1:0]     oRspId;
  logic [31:0]        oRspData;
  logic               oMulEn;
  logic               oMulClr;
  logic [5:0]         oMulK;
  logic [63:0]        oMulU;
  logic [31:0]        oMulMod;
  logic [31:0]        oMulData0;
  logic [31:0]        oMulData1;
  logic [31:0]        iMulData;

  mod_mul_barrett_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr),
    .iCfgValid(iCfgValid), .oCfgReady(oCfgReady),
    .iCfgK(iCfgK), .iCfgU(iCfgU), .iCfgMod(iCfgMod),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqData0(iReqData0), .iReqData1(iReqData1),
    .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspId(oRspId), .oRspData(oRspData),
    .oMulEn(oMulEn), .oMulClr(oMulClr),
    .oMulK(oMulK), .oMulU(oMulU), .oMulMod(oMulMod),
    .oMulData0(oMulData0), .oMulData1(oMulData1),
    .iMulData(iMulData)
  );

  // ---------------- multiplier stand-in ----------------
  logic [31:0] mp [LAT];

  function automatic logic [31:0] modmul(logic [31:0] a, logic [31:0] b, logic [31:0] m);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (m == 32'd0) return 32'd0;
    return 32'(p % {32'd0, m});
  endfunction

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else if (oMulClr) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else if (oMulEn) begin
      mp[0] <= modmul(oMulData0, oMulData1, oMulMod);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign iMulData = mp[LAT-1];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } op_t;
  op_t op_q[$];
  int  gnt_log[$];

  // Shadow controls, applied to the DUT at the falling edge by step().
  logic drv_clr = 1'b0;
  logic drv_cfg_valid = 1'b0;
  logic drv_rsp_ready = 1'b1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_idx(int r);
    foreach (op_q[i]) if (op_q[i].rq == r) return i;
    return -1;
  endfunction

  task automatic add_op(int r, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    op_t o;
    o.rq = r; o.a = a; o.b = b; o.e = e;
    op_q.push_back(o);
  endtask

  // ---------------- driver: one cycle ----------------
  // Drives all inputs at the falling edge, then records the grant that the
  // coming rising edge will take.
  task automatic step();
    int k;
    @(negedge iClk);
    iClr      = drv_clr;
    iCfgValid = drv_cfg_valid;
    iRspReady = drv_rsp_ready;
    for (int r = 0; r < NREQ; r++) begin
      k = first_idx(r);
      iReqValid[r] = (k >= 0);
      iReqData0[32*r +: 32] = (k >= 0) ? op_q[k].a : 32'd0;
      iReqData1[32*r +: 32] = (k >= 0) ? op_q[k].b : 32'd0;
    end
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (iReqValid[r] && oReqReady[r]) begin
        k = first_idx(r);
        exp_q.push_back({IDW'(r), op_q[k].e});
        gnt_log.push_back(r);
        op_q.delete(k);
      end
    end
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((op_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (op_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d ops and %0d results left, expected 0",
               name, op_q.size(), exp_q.size());
    end
  endtask

  task automatic do_cfg(logic [5:0] k, logic [63:0] u, logic [31:0] m, output int waited);
    logic acc;
    iCfgK = k; iCfgU = u; iCfgMod = m;
    drv_cfg_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 100) begin
      step();
      if (oCfgReady) acc = 1'b1;
      else waited++;
    end
    drv_cfg_valid = 1'b0;
    step();
    if (!acc) begin
      checks++; errors++;
      $display("FAIL cfg_accept: got no oCfgReady, expected one within 100 cycles");
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  always @(negedge iClk) begin
    #2;
    if (iRstN && oRspValid && iRspReady) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got id %0d data %0d, expected no response",
                 oRspId, oRspData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id_data", {30'd0, oRspId, oRspData}, {30'd0, mon_e});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    int lat;
    int run;
    int cnt;
    logic [31:0] held;

    // Reset state.
    repeat (2) @(negedge iClk);
    chk("rst_rsp_valid", oRspValid, 0);
    chk("rst_req_ready", oReqReady, 0);
    chk("rst_cfg_ready", oCfgReady, 0);
    chk("rst_mul_mod",   oMulMod,   0);
    chk("rst_mul_u",     oMulU,     0);
    chk("rst_mul_k",     oMulK,     0);
    iRstN = 1'b1;

    // No grant before the first configuration.
    add_op(0, 32'd1, 32'd1, 32'd1);
    step();
    chk("no_grant_before_cfg", oReqReady, 0);
    op_q.delete();

    // Config K=7, U=floor(2^14/97)=168, Mod=97.
    do_cfg(6'd7, 64'd168, 32'd97, waited);
    chk("cfg1_wait", waited, 0);
    chk("cfg1_mod", oMulMod, 97);
    chk("cfg1_k",   oMulK,   7);
    chk("cfg1_u",   oMulU,   168);

    // Single op: 50*60 mod 97 = 90, six cycles later.
    add_op(0, 32'd50, 32'd60, 32'd90);
    step();
    chk("t1_grant", oReqReady, 4'b0001);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!oRspValid && lat < 20);
    chk("t1_latency", lat, 6);
    wait_drain("t1_drain");

    // Requester 1 alone, 8 back-to-back ops: 96*96 mod 97 = 1.
    for (int i = 0; i < 8; i++) add_op(1, 32'd96, 32'd96, 32'd1);
    cnt = 0;
    while (!oRspValid && cnt < 30) begin step(); cnt++; end
    run = 0;
    while (oRspValid && run < 20) begin run++; step(); end
    chk("t2_back_to_back", run, 8);
    wait_drain("t2_drain");

    // Clear resets the RR pointer; then all four requesters compete.
    drv_clr = 1'b1;
    step();
    chk("clr_mul_clr", oMulClr, 1);
    drv_clr = 1'b0;
    gnt_log.delete();
    for (int n = 0; n < 2; n++) begin
      add_op(0, 32'd2,  32'd3,  32'd6);
      add_op(1, 32'd10, 32'd10, 32'd3);
      add_op(2, 32'd7,  32'd8,  32'd56);
      add_op(3, 32'd12, 32'd9,  32'd11);
    end
    wait_drain("t3_drain");
    chk("rr_count", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < gnt_log.size()) chk("rr_order", gnt_log[i], i % NREQ);
    end

    // Backpressure: stall 3 cycles with the pipe full.
    for (int i = 0; i < 10; i++) add_op(2, 32'(10 + i), 32'd3, 32'(30 + 3 * i));
    cnt = 0;
    while (!oRspValid && cnt < 30) begin step(); cnt++; end
    drv_rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("bp_mul_en",    oMulEn,    0);
      chk("bp_req_ready", oReqReady, 0);
      chk("bp_rsp_valid", oRspValid, 1);
      chk("bp_data_held", oRspData,  33);
    end
    drv_rsp_ready = 1'b1;
    wait_drain("bp_drain");

    // Reconfigure with 6 ops in flight: 12*9 mod 97 = 11.
    for (int i = 0; i < 6; i++) add_op(3, 32'd12, 32'd9, 32'd11);
    cnt = 0;
    while (op_q.size() != 0 && cnt < 20) begin step(); cnt++; end
    do_cfg(6'd8, 64'd339, 32'd193, waited);
    chk("cfg2_wait", waited, LAT);
    chk("cfg2_drained", exp_q.size(), 0);
    chk("cfg2_mod", oMulMod, 193);
    chk("cfg2_u",   oMulU,   339);
    add_op(0, 32'd100, 32'd100, 32'd157);
    add_op(0, 32'd192, 32'd192, 32'd1);
    add_op(0, 32'd50,  32'd60,  32'd105);
    wait_drain("cfg2_drain");

    // Clear mid-stream: in-flight results are dropped, config kept.
    add_op(1, 32'd3,  32'd4,  32'd12);
    add_op(1, 32'd5,  32'd6,  32'd30);
    add_op(1, 32'd7,  32'd8,  32'd56);
    add_op(1, 32'd9,  32'd10, 32'd90);
    add_op(1, 32'd11, 32'd12, 32'd132);
    repeat (3) step();
    drv_clr = 1'b1;
    step();
    chk("clr_no_grant", oReqReady, 0);
    drv_clr = 1'b0;
    op_q.delete();
    exp_q.delete();
    step();
    chk("clr_rsp_valid", oRspValid, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (oRspValid) cnt++; end
    chk("clr_no_stale", cnt, 0);
    chk("clr_cfg_kept", oMulMod, 193);
    add_op(2, 32'd100, 32'd100, 32'd157);
    wait_drain("clr_after_drain");

    // Reset mid-stream: results dropped, config cleared.
    for (int i = 0; i < 4; i++) add_op(0, 32'd100, 32'd100, 32'd157);
    repeat (3) step();
    iRstN = 1'b0;
    #1;
    chk("rst2_rsp_valid", oRspValid, 0);
    chk("rst2_mul_mod",   oMulMod,   0);
    op_q.delete();
    exp_q.delete();
    repeat (2) step();
    iRstN = 1'b1;
    add_op(0, 32'd1, 32'd1, 32'd1);
    step();
    chk("rst2_no_grant", oReqReady, 0);
    op_q.delete();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (oRspValid) cnt++; end
    chk("rst2_no_stale", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
